// File: rtl/spi_sevenseg_mux.sv
// Serial slave with a bank of seven-segment digit registers that are scanned
// onto a time-multiplexed display.
// Frames are 16 bits, MSB first: [15:14] cmd, [13:11] addr, [10:8] ignored,
// [7:0] payload. A frame commits on the edge that samples its 16th bit.
// There is no valid/ready handshake: ss low qualifies each mosi bit on every
// sclk rising edge. frame_done (and frame_err for a bad address) pulses for
// exactly one cycle after the commit edge.
module spi_sevenseg_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  ss,
  input  logic                  mosi,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_en,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            SEG_POL = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_POL = SEG_ACTIVE_LOW ? '1 : '0;

  // Hex nibble to {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [14:0]      shift_q, shift_d;
  logic [7:0]       digits_q [NUM_DIGITS];
  logic [7:0]       digits_d [NUM_DIGITS];
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic             frame_done_q, frame_err_q;
  logic             commit, err_d;

  // The completed frame is {shift_q, mosi}; fields are taken from it directly
  logic [1:0] cmd;
  logic [2:0] addr;
  logic [7:0] payload;
  logic       addr_ok;
  logic [7:0] wr_val;

  assign cmd     = shift_q[14:13];
  assign addr    = shift_q[12:10];
  assign payload = {shift_q[6:0], mosi};
  assign addr_ok = ({1'b0, addr} < 4'(NUM_DIGITS));
  assign wr_val  = cmd[0] ? payload : {payload[7], hex7(payload[3:0])};

  // Bit counter and shift register; counter saturates at 16 until ss rises
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    commit    = 1'b0;
    if (ss) begin
      bit_cnt_d = 5'd0;
    end else if (bit_cnt_q < 5'd16) begin
      shift_d   = {shift_q[13:0], mosi};
      bit_cnt_d = bit_cnt_q + 5'd1;
      commit    = (bit_cnt_q == 5'd15);
    end
  end

  // Command decode applied on the commit edge
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = digits_q[i];
    blank_d = blank_q;
    err_d   = 1'b0;
    if (commit) begin
      case (cmd)
        2'b00, 2'b01: begin
          if (addr_ok) begin
            for (int i = 0; i < NUM_DIGITS; i++)
              if (addr == 3'(i)) digits_d[i] = wr_val;
          end else begin
            err_d = 1'b1;
          end
        end
        2'b10:   for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = 8'h00;
        default: blank_d = payload[0];
      endcase
    end
  end

  // Free-running scan counter and digit index, plus next output values
  always_comb begin
    scan_cnt_d = scan_cnt_q + CNT_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
    seg_d    = blank_q ? 8'h00 : digits_q[scan_idx_q];
    dig_en_d = blank_q ? '0 : (NUM_DIGITS'(1) << scan_idx_q);
  end

  // Receive path and digit bank state
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q    <= 5'd0;
      shift_q      <= 15'd0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= 8'h00;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      blank_q      <= blank_d;
      frame_done_q <= commit;
      frame_err_q  <= err_d;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= digits_d[i];
    end
  end

  // Scan state and polarity-adjusted output registers
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      seg_q      <= SEG_POL;
      dig_en_q   <= NUM_DIGITS'(1) ^ DIG_POL;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      seg_q      <= seg_d ^ SEG_POL;
      dig_en_q   <= dig_en_d ^ DIG_POL;
    end
  end

  assign seg        = seg_q;
  assign dig_en     = dig_en_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_sevenseg_mux.sv
// Bench for spi_sevenseg_mux: two instances (active-high and active-low
// outputs) share stimulus and are checked every cycle against a frame-level
// reference model, plus a table of hand-decoded frames and corner sequences.
module tb_spi_sevenseg_mux;

  localparam int ND = 4;
  localparam int SD = 4;

  logic       sclk = 1'b0;
  logic       rst_n, ss, mosi;
  logic [7:0] seg0, seg1;
  logic [3:0] en0, en1;
  logic       fd0, fe0, fd1, fe1;

  spi_sevenseg_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .sclk(sclk), .rst_n(rst_n), .ss(ss), .mosi(mosi),
    .seg(seg0), .dig_en(en0), .frame_done(fd0), .frame_err(fe0));

  spi_sevenseg_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .sclk(sclk), .rst_n(rst_n), .ss(ss), .mosi(mosi),
    .seg(seg1), .dig_en(en1), .frame_done(fd1), .frame_err(fe1));

  // Clock
  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_err    = 0;
  int cnt_done = 0;
  int cnt_err  = 0;

  // Scoreboard: {seg, dig_en, frame_done, frame_err} expected after each edge
  logic [13:0] exp_q[$];

  // Reference model state
  logic [7:0] m_dig [ND];
  logic       m_blank;
  int         m_cycles;
  bit         m_bits[$];
  logic [6:0] hex_tab [16];

  typedef struct {
    logic [15:0] frame;
    logic        err;
    int          idx;
    logic [7:0]  seg;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
    m_blank  = 1'b0;
    m_cycles = 0;
    m_bits.delete();
    exp_q.delete();
  endtask

  // Predict the outputs of one rising edge, then apply its frame effects
  task automatic model_edge(input logic s, input logic m);
    int          idx;
    int          a;
    logic [7:0]  es;
    logic [3:0]  ee;
    logic        c;
    logic        e;
    logic [15:0] w;
    logic [7:0]  pay;
    idx = (m_cycles / SD) % ND;
    es  = m_blank ? 8'h00 : m_dig[idx];
    ee  = m_blank ? 4'h0 : 4'(1 << idx);
    c   = 1'b0;
    e   = 1'b0;
    if (s) begin
      m_bits.delete();
    end else if (m_bits.size() < 16) begin
      m_bits.push_back(m);
      if (m_bits.size() == 16) begin
        w = 16'h0;
        foreach (m_bits[k]) w = {w[14:0], m_bits[k]};
        c   = 1'b1;
        a   = int'(w[13:11]);
        pay = w[7:0];
        case (w[15:14])
          2'd0, 2'd1: begin
            if (a < ND) m_dig[a] = w[14] ? pay : {pay[7], hex_tab[pay[3:0]]};
            else e = 1'b1;
          end
          2'd2:    for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
          default: m_blank = pay[0];
        endcase
      end
    end
    m_cycles++;
    exp_q.push_back({es, ee, c, e});
  endtask

  // Driver: one sclk cycle with given ss/mosi, checked at the falling edge
  task automatic step(input logic s, input logic m);
    logic [13:0] e;
    ss   = s;
    mosi = m;
    model_edge(s, m);
    @(posedge sclk);
    @(negedge sclk);
    e = exp_q.pop_front();
    chk("out_act_high", {18'h0, seg0, en0, fd0, fe0}, {18'h0, e});
    chk("out_act_low", {18'h0, ~seg1, ~en1, fd1, fe1}, {18'h0, e});
    if (fd0) cnt_done++;
    if (fe0) cnt_err++;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int k = 0; k < n; k++) step(1'b0, w[15-k]);
  endtask

  task automatic send_frame(input logic [15:0] w);
    send_bits(w, 16);
    step(1'b1, 1'b0);
  endtask

  // Idle one full scan and capture seg while the given digit is enabled
  task automatic scan_read(input int idx, output logic [7:0] v);
    v = 8'hEE;
    for (int k = 0; k < ND * SD + 1; k++) begin
      step(1'b1, 1'b0);
      if (en0 == 4'(1 << idx)) v = seg0;
    end
  endtask

  initial begin
    logic [7:0]  got;
    logic [15:0] w;
    int          n;
    int          bad;

    hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{16'h108A, 1'b0, 2, 8'hF7};
    vecs[1] = '{16'h4849, 1'b0, 1, 8'h49};
    vecs[2] = '{16'h2808, 1'b1, 2, 8'hF7};
    vecs[3] = '{16'h58FF, 1'b0, 3, 8'hFF};
    vecs[4] = '{16'h1075, 1'b0, 2, 8'h6D};
    vecs[5] = '{16'h9FFF, 1'b0, 3, 8'h00};
    vecs[6] = '{16'h78AA, 1'b1, 0, 8'h00};

    // Reset
    ss    = 1'b1;
    mosi  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge sclk);
    chk("rst_seg0", {24'h0, seg0}, 32'h00);
    chk("rst_en0", {28'h0, en0}, 32'h1);
    chk("rst_seg1", {24'h0, seg1}, 32'hFF);
    chk("rst_en1", {28'h0, en1}, 32'hE);
    chk("rst_pulses", {30'h0, fd0, fe0}, 32'h0);
    rst_n = 1'b1;

    // Idle scan sequence: each digit enabled for SD cycles
    for (int k = 1; k <= 17; k++) begin
      step(1'b1, 1'b0);
      if (k == 4)  chk("scan_e4", {28'h0, en0}, 32'h1);
      if (k == 5)  chk("scan_e5", {28'h0, en0}, 32'h2);
      if (k == 16) chk("scan_e16", {28'h0, en0}, 32'h8);
      if (k == 17) chk("scan_e17", {28'h0, en0}, 32'h1);
    end

    // Table of hand-decoded frames
    for (int v = 0; v < 7; v++) begin
      cnt_done = 0;
      cnt_err  = 0;
      send_frame(vecs[v].frame);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("vec_done_count", cnt_done, 1);
      chk("vec_err_count", cnt_err, {31'h0, vecs[v].err});
      scan_read(vecs[v].idx, got);
      chk("vec_seg", {24'h0, got}, {24'h0, vecs[v].seg});
    end
    for (int i = 0; i < ND; i++) begin
      scan_read(i, got);
      chk("clear_digit", {24'h0, got}, 32'h0);
    end

    // Partial frame discarded, then full frame with trailing bits ignored
    cnt_done = 0;
    send_bits(16'h1003, 9);
    step(1'b1, 1'b0);
    send_bits(16'h0003, 16);
    for (int k = 0; k < 20; k++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);
    chk("partial_done_count", cnt_done, 1);
    scan_read(0, got);
    chk("partial_digit0", {24'h0, got}, 32'h4F);
    scan_read(2, got);
    chk("partial_digit2", {24'h0, got}, 32'h00);

    // Blanking: outputs inactive while scanning continues
    send_frame(16'hC001);
    step(1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 2 * ND * SD; k++) begin
      step(1'b1, 1'b0);
      if (en0 !== 4'h0 || seg0 !== 8'h00 || en1 !== 4'hF || seg1 !== 8'hFF) bad++;
    end
    chk("blank_hold", bad, 0);
    send_frame(16'hC000);
    scan_read(0, got);
    chk("unblank_digit0", {24'h0, got}, 32'h4F);

    // Asynchronous reset in the middle of a frame
    send_bits(16'h4849, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg0", {24'h0, seg0}, 32'h00);
    chk("midrst_en0", {28'h0, en0}, 32'h1);
    chk("midrst_seg1", {24'h0, seg1}, 32'hFF);
    chk("midrst_en1", {28'h0, en1}, 32'hE);
    @(negedge sclk);
    model_reset();
    rst_n = 1'b1;
    w = 16'h4849;
    for (int b = 7; b >= 0; b--) step(1'b0, w[b]);
    step(1'b1, 1'b0);
    scan_read(1, got);
    chk("midrst_digit1", {24'h0, got}, 32'h00);
    scan_read(0, got);
    chk("midrst_digit0", {24'h0, got}, 32'h00);

    // Random frames, partial frames and overlong frames
    for (int r = 0; r < 60; r++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 3) != 0) n = 16 + $urandom_range(0, 3);
      else n = $urandom_range(1, 15);
      for (int k = 0; k < n; k++)
        step(1'b0, (k < 16) ? w[15-k] : 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) step(1'b1, 1'b0);
      if ($urandom_range(0, 4) == 0) repeat (ND * SD) step(1'b1, 1'b0);
    end
    repeat (20) step(1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
